// File: rtl/muldiv_pkg.sv
// Shared constants and types for the ALU control / multiply-divide unit.
package muldiv_pkg;

    // R-type funct codes
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    // ALU operation select encodings
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

    // Order matches funct[1:0] of the mult/div group.
    typedef enum logic [1:0] {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU} mdu_op_e;

    function automatic logic is_muldiv_fn(input logic [5:0] fn);
        return (fn == FN_MULT) || (fn == FN_MULTU) || (fn == FN_DIV) || (fn == FN_DIVU);
    endfunction

    function automatic logic is_mdu_fn(input logic [5:0] fn);
        return is_muldiv_fn(fn) || (fn == FN_MTHI) || (fn == FN_MTLO) ||
               (fn == FN_MFHI) || (fn == FN_MFLO);
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative datapath: shift-add multiply and restoring divide on operand
// magnitudes, with the sign correction applied combinationally on the result.
module muldiv_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step,
    input  mdu_op_e          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    mdu_op_e          op_q;
    logic             neg_q;
    logic             neg_r;
    logic             div0;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] p_hi;
    logic [WIDTH-1:0] p_lo;

    logic             op_signed;
    logic             op_mul;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] nxt_hi;
    logic [WIDTH-1:0] nxt_lo;
    logic [2*WIDTH-1:0] prod;

    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign mag_a     = (op_signed && a[WIDTH-1]) ? -a : a;
    assign mag_b     = (op_signed && b[WIDTH-1]) ? -b : b;
    assign op_mul    = (op_q == OP_MULT) || (op_q == OP_MULTU);

    // One iteration: multiply adds m_q into the upper half and shifts right;
    // divide shifts the remainder left and keeps the trial difference if it
    // did not borrow. p_hi/p_lo are shared as {acc,multiplier} or {rem,quo}.
    always_comb begin
        addend  = p_lo[0] ? m_q : '0;
        sum     = {1'b0, p_hi} + {1'b0, addend};
        shifted = {p_hi, p_lo[WIDTH-1]};
        diff    = shifted - {1'b0, m_q};
        nxt_hi  = p_hi;
        nxt_lo  = p_lo;
        if (op_mul) begin
            nxt_hi = sum[WIDTH:1];
            nxt_lo = {sum[0], p_lo[WIDTH-1:1]};
        end else if (!diff[WIDTH]) begin
            nxt_hi = diff[WIDTH-1:0];
            nxt_lo = {p_lo[WIDTH-2:0], 1'b1};
        end else begin
            nxt_hi = shifted[WIDTH-1:0];
            nxt_lo = {p_lo[WIDTH-2:0], 1'b0};
        end
    end

    // Operand capture on start, one iteration per step cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q  <= OP_MULT;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            div0  <= 1'b0;
            a_q   <= '0;
            m_q   <= '0;
            p_hi  <= '0;
            p_lo  <= '0;
        end else if (start) begin
            op_q  <= op;
            neg_q <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r <= op_signed && a[WIDTH-1];
            div0  <= (b == '0);
            a_q   <= a;
            p_hi  <= '0;
            if ((op == OP_MULT) || (op == OP_MULTU)) begin
                m_q  <= mag_a;
                p_lo <= mag_b;
            end else begin
                m_q  <= mag_b;
                p_lo <= mag_a;
            end
        end else if (step) begin
            p_hi <= nxt_hi;
            p_lo <= nxt_lo;
        end
    end

    // Sign fix; divide-by-zero returns the raw dividend and an all-ones quotient.
    always_comb begin
        prod   = {p_hi, p_lo};
        res_hi = p_hi;
        res_lo = p_lo;
        if (op_mul) begin
            if (neg_q) prod = -prod;
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end else if (div0) begin
            res_hi = a_q;
            res_lo = '1;
        end else begin
            res_hi = neg_r ? -p_hi : p_hi;
            res_lo = neg_q ? -p_lo : p_lo;
        end
    end

endmodule

// File: rtl/alu_muldiv_ctl.sv
// ALU control decode plus multiply/divide sequencing and the HI/LO registers.
//   state | meaning
//   IDLE  | accepting commands; mthi/mtlo write here
//   RUN   | one datapath iteration per cycle, counter WIDTH-1 down to 0
//   FIX   | signed result ready; HI/LO written on the exit edge
module alu_muldiv_ctl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       funct,
    input  logic             valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [3:0]       ALUCtl,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    state_e           state;
    state_e           next_state;
    logic [CW-1:0]    count;
    logic             r_type;
    logic             start;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    assign r_type = valid && (ALUOp == 2'b10);
    assign busy   = (state != IDLE);
    assign stall  = r_type && is_mdu_fn(funct) && busy;
    assign start  = r_type && is_muldiv_fn(funct) && (state == IDLE);
    assign wr_hi  = r_type && (funct == FN_MTHI) && (state == IDLE);
    assign wr_lo  = r_type && (funct == FN_MTLO) && (state == IDLE);

    // ALU operation select, independent of the MDU state.
    always_comb begin
        ALUCtl = ALU_AND;
        case (ALUOp)
            2'b00: ALUCtl = ALU_ADD;
            2'b01: ALUCtl = ALU_SUB;
            2'b11: ALUCtl = ALU_OR;
            default: begin
                case (funct)
                    FN_ADD:  ALUCtl = ALU_ADD;
                    FN_SUB:  ALUCtl = ALU_SUB;
                    FN_AND:  ALUCtl = ALU_AND;
                    FN_OR:   ALUCtl = ALU_OR;
                    FN_XOR:  ALUCtl = ALU_XOR;
                    FN_SLT:  ALUCtl = ALU_SLT;
                    FN_SLTU: ALUCtl = ALU_SLTU;
                    FN_NOR:  ALUCtl = ALU_NOR;
                    default: ALUCtl = ALU_AND;
                endcase
            end
        endcase
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (count == '0) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State, iteration counter, done pulse and HI/LO registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= next_state;
            done  <= (state == FIX);
            if (start) begin
                count <= CW'(WIDTH - 1);
            end else if ((state == RUN) && (count != '0)) begin
                count <= count - CW'(1);
            end
            if (state == FIX) begin
                hi <= res_hi;
                lo <= res_lo;
            end else begin
                if (wr_hi) hi <= a;
                if (wr_lo) lo <= a;
            end
        end
    end

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .step   (state == RUN),
        .op     (mdu_op_e'(funct[1:0])),
        .a      (a),
        .b      (b),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

endmodule

// File: tb/tb_alu_muldiv_ctl.sv
// Directed bench for alu_muldiv_ctl at WIDTH=32.
module tb_alu_muldiv_ctl;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  ALUOp = 2'b00;
    logic [5:0]  funct = 6'b000000;
    logic        valid = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [3:0]  ALUCtl;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vec  = 0;
    int n_miss = 0;

    alu_muldiv_ctl #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .ALUOp  (ALUOp),
        .funct  (funct),
        .valid  (valid),
        .a      (a),
        .b      (b),
        .ALUCtl (ALUCtl),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one mult/div command and wait for it to finish.
    task automatic run_md(input logic [5:0] fn, input logic [31:0] av, input logic [31:0] bv,
                          output int nb, output logic dn, output logic dn_after);
        @(negedge clk);
        ALUOp = 2'b10; funct = fn; a = av; b = bv; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        nb = 0;
        while (busy && nb < 100) begin
            nb++;
            @(negedge clk);
        end
        dn = done;
        @(negedge clk);
        dn_after = done;
    endtask

    typedef struct {
        logic [1:0] op;
        logic [5:0] fn;
        logic [3:0] exp;
    } alu_vec_t;

    alu_vec_t alu_tab[$] = '{
        '{2'b00, 6'b000000, 4'b0010},
        '{2'b01, 6'b100000, 4'b0110},
        '{2'b11, 6'b100110, 4'b0001},
        '{2'b10, 6'b100000, 4'b0010},
        '{2'b10, 6'b100010, 4'b0110},
        '{2'b10, 6'b100100, 4'b0000},
        '{2'b10, 6'b100101, 4'b0001},
        '{2'b10, 6'b100110, 4'b0011},
        '{2'b10, 6'b101010, 4'b0111},
        '{2'b10, 6'b101011, 4'b1000},
        '{2'b10, 6'b100111, 4'b1100},
        '{2'b10, 6'b111111, 4'b0000},
        '{2'b10, 6'b011000, 4'b0000}
    };

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        int ns;
        int ndone;
        int alu_bad;
        logic dn;
        logic dn_after;

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        reset = 1'b0;

        foreach (alu_tab[i]) begin
            ALUOp = alu_tab[i].op; funct = alu_tab[i].fn;
            #1;
            chk($sformatf("aluctl_%0d", i), ALUCtl, alu_tab[i].exp);
        end

        run_md(FN_MULT, 32'hFFFFFFFD, 32'd7, nb, dn, dn_after);
        chk("mult_busy_cycles", nb, 33);
        chk("mult_done", dn, 1'b1);
        chk("mult_done_once", dn_after, 1'b0);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFEB);

        run_md(FN_DIVU, 32'd100, 32'd7, nb, dn, dn_after);
        chk("divu_busy_cycles", nb, 33);
        chk("divu_lo", lo, 32'h0000000E);
        chk("divu_hi", hi, 32'h00000002);

        run_md(FN_DIV, 32'hFFFFFFF9, 32'd2, nb, dn, dn_after);
        chk("div_neg_lo", lo, 32'hFFFFFFFD);
        chk("div_neg_hi", hi, 32'hFFFFFFFF);

        run_md(FN_DIV, 32'h00001234, 32'd0, nb, dn, dn_after);
        chk("div0_busy_cycles", nb, 33);
        chk("div0_done", dn, 1'b1);
        chk("div0_lo", lo, 32'hFFFFFFFF);
        chk("div0_hi", hi, 32'h00001234);

        // multu followed by a held mflo: stalled every busy cycle, released in the done cycle
        @(negedge clk);
        ALUOp = 2'b10; funct = FN_MULTU; a = 32'hFFFFFFFF; b = 32'd2; valid = 1'b1;
        @(negedge clk);
        funct = FN_MFLO;
        nb = 0; ns = 0; alu_bad = 0;
        while (busy && nb < 100) begin
            if (stall) ns++;
            if (ALUCtl !== 4'b0000) alu_bad++;
            nb++;
            @(negedge clk);
        end
        chk("stall_cycles", ns, 33);
        chk("stall_in_done", stall, 1'b0);
        chk("stall_done", done, 1'b1);
        chk("stall_aluctl", alu_bad, 0);
        valid = 1'b0;
        chk("multu_hi", hi, 32'h00000001);
        chk("multu_lo", lo, 32'hFFFFFFFE);

        // mthi while busy is stalled and must not touch HI
        @(negedge clk);
        ALUOp = 2'b10; funct = FN_DIVU; a = 32'd100; b = 32'd7; valid = 1'b1;
        @(negedge clk);
        funct = FN_MTHI; a = 32'hDEADBEEF;
        #1;
        chk("mthi_busy_stall", stall, 1'b1);
        @(negedge clk);
        valid = 1'b0;
        nb = 0;
        while (busy && nb < 100) begin
            nb++;
            @(negedge clk);
        end
        chk("mthi_busy_hi", hi, 32'h00000002);
        chk("mthi_busy_lo", lo, 32'h0000000E);

        // mthi/mtlo in IDLE
        @(negedge clk);
        ALUOp = 2'b10; funct = FN_MTHI; a = 32'hCAFEBABE; valid = 1'b1;
        @(negedge clk);
        chk("mthi_hi", hi, 32'hCAFEBABE);
        chk("mthi_busy", busy, 1'b0);
        funct = FN_MTLO; a = 32'h12345678;
        @(negedge clk);
        chk("mtlo_lo", lo, 32'h12345678);
        chk("mtlo_hi_kept", hi, 32'hCAFEBABE);
        chk("mtlo_done", done, 1'b0);
        funct = FN_MFHI;
        #1;
        chk("mfhi_idle_stall", stall, 1'b0);
        valid = 1'b0;

        // reset at busy cycle 10 of a mult
        @(negedge clk);
        ALUOp = 2'b10; funct = FN_MULT; a = 32'd5; b = 32'd7; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_reset_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        chk("abort_lo_after", lo, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
